// File: rtl/led_pattern_sequencer_pkg.sv
// Shared mode and direction encodings for the LED pattern sequencer.
package led_pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_pattern_sequencer_rise_detect.sv
// Rising-edge detector for a level already synchronous to clock.
// Resets its history high so an input that is already high at release is not seen as an edge.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic tick_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tick_q <= 1'b1;
    else       tick_q <= in;
  end

  assign rise = in & ~tick_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps a selectable LED pattern (hold, blink, chase, bounce) on each rising edge of tick_in.
// All outputs are registered; a mode change reloads the pattern's start value and overrides a step.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic             step_pulse,
  output logic             cycle_done
);

  localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);

  logic  rise;
  logic  step;
  logic  mode_change;
  mode_e mode_q;
  dir_e  dir;

  rise_detect u_rise_detect (
    .clock (clock),
    .reset (reset),
    .in    (tick_in),
    .rise  (rise)
  );

  assign step        = rise & enable;
  assign mode_change = (mode != mode_q);

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [WIDTH-1:0] init_leds(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_HOLD:  r = cur;
      MODE_BLINK: r = '0;
      default:    r = LED_ONE;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leds       <= '0;
      step_pulse <= 1'b0;
      cycle_done <= 1'b0;
      mode_q     <= MODE_HOLD;
      dir        <= DIR_LEFT;
    end else begin
      mode_q     <= mode_e'(mode);
      step_pulse <= step;
      cycle_done <= 1'b0;
      if (mode_change) begin
        leds <= init_leds(mode, leds);
        dir  <= DIR_LEFT;
      end else if (step) begin
        case (mode_q)
          MODE_HOLD: ;
          MODE_BLINK: begin
            leds       <= (leds == '0) ? '1 : '0;
            cycle_done <= (leds == '1);
          end
          MODE_CHASE: begin
            if (!is_onehot(leds)) begin
              leds <= LED_ONE;
            end else begin
              leds       <= {leds[WIDTH-2:0], leds[WIDTH-1]};
              cycle_done <= leds[WIDTH-1];
            end
          end
          MODE_BOUNCE: begin
            // A stray pattern restarts from bit 0 rather than shifting out to zero.
            if (!is_onehot(leds)) begin
              leds <= LED_ONE;
              dir  <= DIR_LEFT;
            end else if (dir == DIR_LEFT) begin
              leds <= leds << 1;
              if (leds[WIDTH-2]) dir <= DIR_RIGHT;
            end else begin
              leds <= leds >> 1;
              if (leds[1]) begin
                dir        <= DIR_LEFT;
                cycle_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized and scenario bench for led_pattern_sequencer (WIDTH=4) against a position-based pattern model.
module tb_led_pattern_sequencer;

  localparam int W = 4;
  localparam logic [W-1:0] ALL = '1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         tick_in = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] leds;
  logic         step_pulse;
  logic         cycle_done;

  int vectors = 0;
  int fails = 0;

  // Reference model: pattern described by a position index within its cycle.
  logic         m_tick_q;
  logic [1:0]   m_mode_q;
  logic [W-1:0] m_leds;
  logic         m_step;
  logic         m_done;
  int           m_pos;

  led_pattern_sequencer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick_in    (tick_in),
    .enable     (enable),
    .mode       (mode),
    .leds       (leds),
    .step_pulse (step_pulse),
    .cycle_done (cycle_done)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] bounce_leds(input int p);
    return (p < W) ? W'(1 << p) : W'(1 << (2*W - 2 - p));
  endfunction

  task automatic model_reset();
    m_tick_q = 1'b1;
    m_mode_q = 2'd0;
    m_leds   = '0;
    m_step   = 1'b0;
    m_done   = 1'b0;
    m_pos    = 0;
  endtask

  task automatic model_edge(input logic t, input logic e, input logic [1:0] m);
    logic stp;
    stp    = t && !m_tick_q && e;
    m_step = stp;
    m_done = 1'b0;
    if (m != m_mode_q) begin
      m_pos = 0;
      if (m == 2'd1) m_leds = '0;
      else if (m != 2'd0) m_leds = 1;
    end else if (stp) begin
      case (m)
        2'd1: begin
          m_done = (m_leds == ALL);
          m_leds = (m_leds == '0) ? ALL : '0;
        end
        2'd2: begin
          m_pos  = (m_pos + 1) % W;
          m_done = (m_pos == 0);
          m_leds = W'(1 << m_pos);
        end
        2'd3: begin
          m_pos  = (m_pos + 1) % (2*W - 2);
          m_done = (m_pos == 0);
          m_leds = bounce_leds(m_pos);
        end
        default: ;
      endcase
    end
    m_tick_q = t;
    m_mode_q = m;
  endtask

  task automatic cyc(input logic t, input logic e, input logic [1:0] m);
    tick_in = t;
    enable  = e;
    mode    = m;
    @(posedge clock);
    model_edge(t, e, m);
    #1;
  endtask

  task automatic test_reset();
    tick_in = 1'b1; enable = 1'b1; mode = 2'd2;
    #2 reset = 1'b1;
    #1;
    if ({leds, step_pulse, cycle_done} !== {4'b0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: dut leds=%b step=%b done=%b, expected 0000 0 0", leds, step_pulse, cycle_done);
    end
    vectors++;
    model_reset();
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 2'd2);
      if ({leds, step_pulse, cycle_done} !== {4'b0001, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset_release c%0d: dut leds=%b step=%b done=%b, expected 0001 0 0", i, leds, step_pulse, cycle_done);
      end
      vectors++;
    end
  endtask

  task automatic test_chase();
    int dones = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        cyc((i >= 4), 1'b1, 2'd2);
        if ({leds, step_pulse, cycle_done} !== {m_leds, m_step, m_done}) begin
          fails++;
          $display("FAIL chase r%0d c%0d: dut %b/%b/%b model %b/%b/%b", r, i, leds, step_pulse, cycle_done, m_leds, m_step, m_done);
        end
        vectors++;
        if (cycle_done) dones++;
      end
    end
    if (leds !== 4'b0001 || dones != 1) begin
      fails++;
      $display("FAIL chase_wrap: dut leds=%b dones=%0d, expected 0001 and 1", leds, dones);
    end
    vectors++;
  endtask

  task automatic test_bounce();
    logic [W-1:0] exp_seq [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [5:0] done_seen = '0;
    int k = 0;
    cyc(1'b0, 1'b1, 2'd3);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        cyc((i == 1 || i == 2), 1'b1, 2'd3);
        if ({leds, step_pulse, cycle_done} !== {m_leds, m_step, m_done}) begin
          fails++;
          $display("FAIL bounce r%0d c%0d: dut %b/%b/%b model %b/%b/%b", r, i, leds, step_pulse, cycle_done, m_leds, m_step, m_done);
        end
        vectors++;
        if (step_pulse && k < 6) begin
          if (leds !== exp_seq[k]) begin
            fails++;
            $display("FAIL bounce_seq step%0d: dut leds=%b expected %b", k, leds, exp_seq[k]);
          end
          vectors++;
          done_seen[k] = cycle_done;
          k++;
        end
      end
    end
    if (k != 6 || done_seen !== 6'b100000) begin
      fails++;
      $display("FAIL bounce_done: steps=%0d done_mask=%b, expected 6 and 100000", k, done_seen);
    end
    vectors++;
  endtask

  task automatic test_blink_enable();
    logic en_pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_after [5] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    cyc(1'b0, 1'b1, 2'd1);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        cyc((i == 1 || i == 2), en_pat[r], 2'd1);
        if ({leds, step_pulse, cycle_done} !== {m_leds, m_step, m_done}) begin
          fails++;
          $display("FAIL blink r%0d c%0d: dut %b/%b/%b model %b/%b/%b", r, i, leds, step_pulse, cycle_done, m_leds, m_step, m_done);
        end
        vectors++;
        if (i == 1 && ({leds, step_pulse, cycle_done} !== {exp_after[r], en_pat[r], (r == 1)})) begin
          fails++;
          $display("FAIL blink_step r%0d: dut %b/%b/%b expected %b/%b/%b", r, leds, step_pulse, cycle_done, exp_after[r], en_pat[r], (r == 1));
        end
        if (i == 1) vectors++;
      end
    end
  endtask

  task automatic test_mode_change_step();
    cyc(1'b0, 1'b1, 2'd2);
    for (int r = 0; r < 2; r++) begin
      cyc(1'b1, 1'b1, 2'd2);
      cyc(1'b0, 1'b1, 2'd2);
    end
    if (leds !== 4'b0100) begin
      fails++;
      $display("FAIL modechg_setup: dut leds=%b expected 0100", leds);
    end
    vectors++;
    cyc(1'b1, 1'b1, 2'd3);
    if ({leds, step_pulse, cycle_done} !== {4'b0001, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL modechg_coincident: dut %b/%b/%b expected 0001/1/0", leds, step_pulse, cycle_done);
    end
    vectors++;
    cyc(1'b0, 1'b1, 2'd3);
    cyc(1'b1, 1'b1, 2'd3);
    if ({leds, step_pulse, cycle_done} !== {4'b0010, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL modechg_next: dut %b/%b/%b expected 0010/1/0", leds, step_pulse, cycle_done);
    end
    vectors++;
  endtask

  task automatic test_async_reset();
    // from 0010 going left: 0100, 1000, then 0100 heading right
    for (int r = 0; r < 3; r++) begin
      cyc(1'b0, 1'b1, 2'd3);
      cyc(1'b1, 1'b1, 2'd3);
    end
    if ({leds, step_pulse} !== {4'b0100, 1'b1}) begin
      fails++;
      $display("FAIL areset_setup: dut leds=%b step=%b expected 0100/1", leds, step_pulse);
    end
    vectors++;
    #2 reset = 1'b1;
    #1;
    if ({leds, step_pulse, cycle_done} !== {4'b0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL areset_immediate: dut %b/%b/%b expected 0000/0/0", leds, step_pulse, cycle_done);
    end
    vectors++;
    model_reset();
    tick_in = 1'b0; enable = 1'b1; mode = 2'd3;
    @(posedge clock); #2;
    reset = 1'b0;
    cyc(1'b0, 1'b1, 2'd3);
    if ({leds, step_pulse, cycle_done} !== {4'b0001, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL areset_release: dut %b/%b/%b expected 0001/0/0", leds, step_pulse, cycle_done);
    end
    vectors++;
    cyc(1'b1, 1'b1, 2'd3);
    if ({leds, step_pulse, cycle_done} !== {4'b0010, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL areset_dir_left: dut %b/%b/%b expected 0010/1/0", leds, step_pulse, cycle_done);
    end
    vectors++;
  endtask

  task automatic test_random();
    logic t = 1'b0;
    logic [1:0] m = 2'd3;
    logic e;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) t = ~t;
      if ($urandom_range(0, 24) == 0) m = 2'($urandom_range(0, 3));
      e = ($urandom_range(0, 7) != 0);
      cyc(t, e, m);
      if ({leds, step_pulse, cycle_done} !== {m_leds, m_step, m_done}) begin
        fails++;
        $display("FAIL random c%0d: dut %b/%b/%b model %b/%b/%b", i, leds, step_pulse, cycle_done, m_leds, m_step, m_done);
      end
      vectors++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_chase();
    test_bounce();
    test_blink_enable();
    test_mode_change_step();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
